// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART TX frame scheduler.
//   state_e : scheduler FSM states
//   clog2   : ceiling log2 for sizing counters and indices (clog2(1) = 0)
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_rr_arb.sv
// Combinational round-robin picker.
//   req     in  NUM_REQ  request vector
//   ptr     in  IDX_W    highest-priority index this round
//   gnt_oh  out NUM_REQ  one-hot grant (zero when nothing requests)
//   gnt_idx out IDX_W    index of the granted requester
//   gnt_vld out 1        at least one request present
module uart_tx_rr_arb
    import uart_tx_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    int j;

    // Walk from ptr upward with wrap; the first set bit wins.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        j       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!gnt_vld && req[j]) begin
                gnt_vld   = 1'b1;
                gnt_idx   = IDX_W'(j);
                gnt_oh[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ requesters.
//   CLK, RST            clock (rising) / async active-low reset
//   REQ, REQ_DATA,
//   REQ_PAR_EN/TYP      per-requester frame request, payload and parity config
//   ACK                 one-hot pulse when the TX picks up the requester's frame
//   P_DATA, DATA_VALID,
//   PAR_EN, PAR_TYP     drive the TX; config held for the whole frame
//   Busy                TX busy
//   SCHED_BUSY          scheduler not in IDLE
//   TO_ERR, TO_ERR_CLR  sticky "TX never started" flag and its clear
module uart_tx_frame_scheduler
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]            REQ_PAR_EN,
    input  logic [NUM_REQ-1:0]            REQ_PAR_TYP,
    output logic [NUM_REQ-1:0]            ACK,
    output logic [DATA_WIDTH-1:0]         P_DATA,
    output logic                          DATA_VALID,
    output logic                          PAR_EN,
    output logic                          PAR_TYP,
    input  logic                          Busy,
    output logic                          SCHED_BUSY,
    output logic                          TO_ERR,
    input  logic                          TO_ERR_CLR
);

    localparam int                IDX_W   = clog2(NUM_REQ);
    localparam int                CNT_W   = clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BUSY_TIMEOUT);
    localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(NUM_REQ - 1);

    state_e                  state_q,   state_d;
    logic [IDX_W-1:0]        ptr_q,     ptr_d;
    logic [IDX_W-1:0]        gnt_idx_q, gnt_idx_d;
    logic [NUM_REQ-1:0]      gnt_oh_q,  gnt_oh_d;
    logic [DATA_WIDTH-1:0]   p_data_q,  p_data_d;
    logic                    par_en_q,  par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic                    to_err_q,  to_err_d;
    logic                    to_set;

    logic [NUM_REQ-1:0]      arb_oh;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_vld;

    uart_tx_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (REQ),
        .ptr     (ptr_q),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        gnt_oh_d  = gnt_oh_q;
        p_data_d  = p_data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        cnt_d     = cnt_q;
        to_set    = 1'b0;
        ACK       = '0;
        case (state_q)
            IDLE: begin
                // An externally started frame (Busy with us idle) blocks new launches.
                if (arb_vld && !Busy) begin
                    gnt_idx_d = arb_idx;
                    gnt_oh_d  = arb_oh;
                    p_data_d  = REQ_DATA[arb_idx*DATA_WIDTH +: DATA_WIDTH];
                    par_en_d  = REQ_PAR_EN[arb_idx];
                    par_typ_d = REQ_PAR_TYP[arb_idx];
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (Busy) begin
                    ACK     = gnt_oh_q;
                    ptr_d   = (gnt_idx_q == IDX_MAX) ? '0 : gnt_idx_q + 1'b1;
                    state_d = WAIT_DONE;
                end else begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    // Abort without advancing the pointer so the same requester retries first.
                    if (cnt_d == CNT_MAX) begin
                        to_set  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!Busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Set wins over a coincident clear.
        to_err_d = to_set ? 1'b1 : (TO_ERR_CLR ? 1'b0 : to_err_q);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            gnt_oh_q  <= '0;
            p_data_q  <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            cnt_q     <= '0;
            to_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_oh_q  <= gnt_oh_d;
            p_data_q  <= p_data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            cnt_q     <= cnt_d;
            to_err_q  <= to_err_d;
        end
    end

    assign DATA_VALID = (state_q == LAUNCH);
    assign SCHED_BUSY = (state_q != IDLE);
    assign P_DATA     = p_data_q;
    assign PAR_EN     = par_en_q;
    assign PAR_TYP    = par_typ_q;
    assign TO_ERR     = to_err_q;

endmodule

// File: tb/tb_uart_tx_frame_scheduler.sv
// Bench for uart_tx_frame_scheduler with a simple TX busy model and a frame scoreboard.
module tb_uart_tx_frame_scheduler;

    localparam int DW    = 8;
    localparam int NR    = 4;
    localparam int FRAME = 10;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [NR-1:0] REQ = '0;
    logic [NR*DW-1:0] REQ_DATA = {8'hC3, 8'h5A, 8'h3C, 8'hA5};
    logic [NR-1:0] REQ_PAR_EN  = 4'b1101;
    logic [NR-1:0] REQ_PAR_TYP = 4'b0100;
    logic [NR-1:0] ACK;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID, PAR_EN, PAR_TYP, Busy, SCHED_BUSY, TO_ERR;
    logic          TO_ERR_CLR = 1'b0;

    logic          ext_busy  = 1'b0;
    logic          tx_stuck  = 1'b0;
    int            tx_cnt;

    always #5 CLK = ~CLK;

    uart_tx_frame_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BUSY_TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_DATA(REQ_DATA),
        .REQ_PAR_EN(REQ_PAR_EN), .REQ_PAR_TYP(REQ_PAR_TYP), .ACK(ACK),
        .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .Busy(Busy), .SCHED_BUSY(SCHED_BUSY), .TO_ERR(TO_ERR), .TO_ERR_CLR(TO_ERR_CLR)
    );

    // TX model: takes a frame on DATA_VALID when idle, busy for FRAME cycles.
    always @(posedge CLK or negedge RST) begin
        if (!RST)                         tx_cnt <= 0;
        else if (tx_cnt != 0)             tx_cnt <= tx_cnt - 1;
        else if (DATA_VALID && !tx_stuck) tx_cnt <= FRAME;
    end
    assign Busy = (tx_cnt != 0) || ext_busy;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        int          idx;
        logic [DW-1:0] data;
        logic        pe;
        logic        pt;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic pend_vld = 1'b0;
    int   n_ack    = 0;

    // Expected frame contents come from the requester tables, not from the DUT.
    task automatic push_exp(input int idx);
        exp_t e;
        logic [NR*DW-1:0] d;
        d      = REQ_DATA;
        e.idx  = idx;
        e.data = d[idx*DW +: DW];
        e.pe   = REQ_PAR_EN[idx];
        e.pt   = REQ_PAR_TYP[idx];
        exp_q.push_back(e);
    endtask

    // Monitor: pops expected frames on each launch, checks ACK and held outputs.
    always @(negedge CLK) begin
        if (RST) begin
            if (DATA_VALID) begin
                chk("dv_vs_busy", Busy, 0);
                chk("dv_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur      = exp_q.pop_front();
                    pend_vld = 1'b1;
                end
            end
            if (ACK != '0) begin
                chk("ack_grant", ACK, pend_vld ? (32'd1 << cur.idx) : 32'd0);
                pend_vld = 1'b0;
                n_ack++;
            end
            if (SCHED_BUSY) begin
                chk("p_data_hold", P_DATA, cur.data);
                chk("par_en_hold", PAR_EN, cur.pe);
                chk("par_typ_hold", PAR_TYP, cur.pt);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 40 && ACK == '0; i++) tick();
        chk("wait_ack", ACK != '0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && (SCHED_BUSY || Busy); i++) tick();
        chk("wait_idle", SCHED_BUSY || Busy, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ack"}, ACK, 0);
        chk({tag, "_dv"}, DATA_VALID, 0);
        chk({tag, "_pdata"}, P_DATA, 0);
        chk({tag, "_paren"}, PAR_EN, 0);
        chk({tag, "_partyp"}, PAR_TYP, 0);
        chk({tag, "_toerr"}, TO_ERR, 0);
        chk({tag, "_sbusy"}, SCHED_BUSY, 0);
    endtask

    int acks_seen;
    int ack_base;

    initial begin
        #1;
        chk_reset_vals("rst");
        tick();
        tick();
        RST = 1'b1;
        tick();

        // 1: single request, latency and ACK
        REQ = 4'b0001;
        push_exp(0);
        tick();
        chk("t1_dv_latency", DATA_VALID, 1);
        wait_ack();
        chk("t1_ack", ACK, 4'b0001);
        REQ = '0;
        tick();
        chk("t1_dv_one_cycle", DATA_VALID, 0);
        chk("t1_pdata_wait_done", P_DATA, 8'hA5);
        wait_idle();

        // 5: external Busy blocks launch (pointer is now 1)
        ext_busy = 1'b1;
        REQ      = 4'b0010;
        push_exp(1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_dv", DATA_VALID, 0);
            chk("t5_idle", SCHED_BUSY, 0);
        end
        ext_busy = 1'b0;
        tick();
        chk("t5_dv_after_busy", DATA_VALID, 1);
        wait_ack();
        chk("t5_ack", ACK, 4'b0010);
        REQ = '0;
        wait_idle();

        // 3/4: timeout with requester 2 (pointer now 2), retry, clear priority
        tx_stuck = 1'b1;
        ack_base = n_ack;
        REQ      = 4'b0100;
        push_exp(2);
        tick();
        chk("t3_dv", DATA_VALID, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_no_ack", ACK, 0);
        end
        chk("t3_toerr_not_yet", TO_ERR, 0);
        tick();
        chk("t3_toerr_set", TO_ERR, 1);
        chk("t3_back_idle", SCHED_BUSY, 0);
        // Requester 3 joins; the retry must still go to requester 2.
        REQ = 4'b1100;
        push_exp(2);
        tick();
        chk("t3_relaunch_dv", DATA_VALID, 1);
        REQ = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_no_ack", ACK, 0);
        end
        TO_ERR_CLR = 1'b1;
        tick();
        TO_ERR_CLR = 1'b0;
        chk("t4_set_beats_clr", TO_ERR, 1);
        chk("t4_idle", SCHED_BUSY, 0);
        tick();
        TO_ERR_CLR = 1'b1;
        tick();
        TO_ERR_CLR = 1'b0;
        chk("t4_clr", TO_ERR, 0);
        chk("t3_ack_count", n_ack - ack_base, 0);
        tx_stuck = 1'b0;
        tick();

        // 2: reset, then all four requesting
        RST = 1'b0;
        #1;
        chk_reset_vals("rst2");
        tick();
        RST = 1'b1;
        tick();
        push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
        REQ       = 4'b1111;
        acks_seen = 0;
        for (int i = 0; i < 200 && acks_seen < 5; i++) begin
            tick();
            if (ACK != '0) acks_seen++;
            if (acks_seen == 5) REQ = '0;
        end
        REQ = '0;
        chk("t2_acks", acks_seen, 5);
        wait_idle();
        chk("t2_queue_empty", exp_q.size(), 0);

        // 6: reset during WAIT_DONE (pointer now 1)
        REQ = 4'b0010;
        push_exp(1);
        wait_ack();
        REQ = '0;
        tick();
        chk("t6_wait_done", SCHED_BUSY, 1);
        #2;
        RST = 1'b0;
        #1;
        chk_reset_vals("t6_rst");
        chk("t6_busy_rst", Busy, 0);
        tick();
        tick();
        RST = 1'b1;
        // Pointer must be back at 0, so requester 1 beats requester 2.
        REQ = 4'b0110;
        push_exp(1);
        wait_ack();
        chk("t6_ptr_reset", ACK, 4'b0010);
        REQ = '0;
        wait_idle();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
